spi_frame_ctrl: RTL and testbench

- Sequencer between the SPI receive buffer and the frame RAM.
- Consumes the buffered 16-bit word stream plus its Mode flag (1 = command, 0 = data/argument) over valid/ready.
- Decodes window and write commands, then turns pixel words into addressed frame-RAM writes inside the programmed window, with wrap-around.

---
 rtl/spi_frame_pkg.sv | 35 +++
 rtl/spi_win_cursor.sv | 108 ++++++++++
 rtl/spi_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared constants, state encoding and helpers for the
// SPI frame sequencer (spi_frame_ctrl and spi_win_cursor).
package spi_frame_pkg;

  // Default geometry of the panel frame buffer
  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 240;
  localparam int ADDR_W_DEF = 17;

  // Command codes carried in i_data[7:0] when i_mode=1
  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Pixel / line coordinate
  typedef logic [8:0] coord_t;

  // Decode FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARG   = 2'd1,
    S_PIXEL = 2'd2
  } state_e;

  // Limit a raw 16-bit argument to the last valid coordinate (res-1)
  function automatic coord_t clamp_coord(input logic [15:0] v, input int res);
    if ({16'd0, v} >= 32'(res)) begin
      clamp_coord = coord_t'(res - 1);
    end else begin
      clamp_coord = coord_t'(v);
    end
  endfunction

endpackage

// File: rtl/spi_win_cursor.sv
// spi_win_cursor: window registers plus the write cursor (x, y, row_base,
// addr). i_set_x / i_set_y commit a clamped start/end pair atomically,
// i_load restarts the cursor at the window origin, i_advance steps it in
// raster order with wrap-around inside the window.
// With SPI_FRAME_DONE_EN defined, o_last flags the window's final pixel.
module spi_win_cursor
  import spi_frame_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic              i_set_x,
  input  logic              i_set_y,
  input  logic [15:0]       i_arg_start,
  input  logic [15:0]       i_arg_end,
  output logic [ADDR_W-1:0] o_addr
`ifdef SPI_FRAME_DONE_EN
  ,
  output logic              o_last
`endif
);

  localparam logic [ADDR_W-1:0] L_HRES = ADDR_W'(H_RES);

  coord_t r_x_start, r_x_end, r_y_start, r_y_end;
  logic [ADDR_W-1:0] r_ys_base;   // y_start * H_RES, refreshed on PASET commit
  coord_t r_x, r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;

  coord_t w_cx_s, w_cx_e, w_cy_s, w_cy_e;
  coord_t w_cx_e_fix, w_cy_e_fix;
  logic [ADDR_W-1:0] w_xs_ext;

  // Clamp incoming argument pairs; an inverted pair collapses to the start
  always_comb begin
    w_cx_s     = clamp_coord(i_arg_start, H_RES);
    w_cx_e     = clamp_coord(i_arg_end, H_RES);
    w_cy_s     = clamp_coord(i_arg_start, V_RES);
    w_cy_e     = clamp_coord(i_arg_end, V_RES);
    w_cx_e_fix = (w_cx_s > w_cx_e) ? w_cx_s : w_cx_e;
    w_cy_e_fix = (w_cy_s > w_cy_e) ? w_cy_s : w_cy_e;
    w_xs_ext   = ADDR_W'(r_x_start);
  end

  // Window registers: full frame after reset, updated as a pair on commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x_start <= '0;
      r_x_end   <= coord_t'(H_RES - 1);
      r_y_start <= '0;
      r_y_end   <= coord_t'(V_RES - 1);
      r_ys_base <= '0;
    end else begin
      if (i_set_x) begin
        r_x_start <= w_cx_s;
        r_x_end   <= w_cx_e_fix;
      end
      if (i_set_y) begin
        r_y_start <= w_cy_s;
        r_y_end   <= w_cy_e_fix;
        // The only multiply in the design, by a constant, done once per PASET
        r_ys_base <= ADDR_W'(32'(w_cy_s) * 32'(H_RES));
      end
    end
  end

  // Cursor: reload at window origin, or step in raster order with wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_x        <= r_x_start;
      r_y        <= r_y_start;
      r_row_base <= r_ys_base;
      r_addr     <= r_ys_base + w_xs_ext;
    end else if (i_advance) begin
      if (r_x != r_x_end) begin
        r_x    <= r_x + 9'd1;
        r_addr <= r_addr + 1'b1;
      end else if (r_y != r_y_end) begin
        r_x        <= r_x_start;
        r_y        <= r_y + 9'd1;
        r_row_base <= r_row_base + L_HRES;
        r_addr     <= r_row_base + L_HRES + w_xs_ext;
      end else begin
        r_x        <= r_x_start;
        r_y        <= r_y_start;
        r_row_base <= r_ys_base;
        r_addr     <= r_ys_base + w_xs_ext;
      end
    end
  end

  assign o_addr = r_addr;
`ifdef SPI_FRAME_DONE_EN
  assign o_last = (r_x == r_x_end) && (r_y == r_y_end);
`endif

endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes the buffered SPI word stream (command/data) and
// turns pixel words into registered frame-RAM writes inside the programmed
// window. Optional feature macro: SPI_FRAME_DONE_EN adds o_frame_done and
// o_frame_cnt (end-of-window write completion pulse and counter).
//
// Handshake: a word transfers on i_valid && o_ready. o_ready is high when no
// write is pending or the pending write completes this cycle
// (o_ram_we && i_ram_ready). A write request holds o_ram_we, o_ram_addr and
// o_ram_wdata stable until i_ram_ready is seen.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_valid,
  input  logic              i_mode,
  input  logic [15:0]       i_data,
  output logic              o_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_wdata,
  input  logic              i_ram_ready,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
`ifdef SPI_FRAME_DONE_EN
  ,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt
`endif
);

  state_e r_state, w_next_state;

  logic              r_arg_idx;   // 0: expecting start, 1: expecting end
  logic              r_arg_sel;   // 0: CASET (x), 1: PASET (y)
  logic [15:0]       r_arg0;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [15:0]       r_ram_wdata;

  logic              w_accept, w_cmd_acc, w_dat_acc;
  logic [7:0]        w_cmd;
  logic              w_pix, w_load, w_commit, w_set_x, w_set_y;
  logic [ADDR_W-1:0] w_cur_addr;

  assign o_ready   = !r_ram_we || i_ram_ready;
  assign w_accept  = i_valid && o_ready;
  assign w_cmd_acc = w_accept && i_mode;
  assign w_dat_acc = w_accept && !i_mode;
  assign w_cmd     = i_data[7:0];
  assign w_pix     = w_dat_acc && (r_state == S_PIXEL);
  assign w_load    = w_cmd_acc && (w_cmd == CMD_RAMWR);
  assign w_commit  = w_dat_acc && (r_state == S_ARG) && r_arg_idx;
  assign w_set_x   = w_commit && !r_arg_sel;
  assign w_set_y   = w_commit && r_arg_sel;

`ifdef SPI_FRAME_DONE_EN
  logic w_cur_last;
  logic r_ram_last;
  logic w_frame_done;
  logic [7:0] r_frame_cnt;
`endif

  spi_win_cursor #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_cursor (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_load),
    .i_advance  (w_pix),
    .i_set_x    (w_set_x),
    .i_set_y    (w_set_y),
    .i_arg_start(r_arg0),
    .i_arg_end  (i_data),
    .o_addr     (w_cur_addr)
`ifdef SPI_FRAME_DONE_EN
    ,
    .o_last     (w_cur_last)
`endif
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: any command aborts the current state
  always_comb begin
    w_next_state = r_state;
    if (w_cmd_acc) begin
      case (w_cmd)
        CMD_CASET, CMD_PASET: w_next_state = S_ARG;
        CMD_RAMWR:            w_next_state = S_PIXEL;
        default:              w_next_state = S_IDLE;
      endcase
    end else if (w_commit) begin
      w_next_state = S_IDLE;
    end
  end

  // Argument collection: first word held in r_arg0, second commits the pair
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_arg_idx <= 1'b0;
      r_arg_sel <= 1'b0;
      r_arg0    <= '0;
    end else if (w_cmd_acc) begin
      r_arg_idx <= 1'b0;
      r_arg_sel <= (w_cmd == CMD_PASET);
    end else if (w_dat_acc && (r_state == S_ARG)) begin
      if (!r_arg_idx) begin
        r_arg0    <= i_data;
        r_arg_idx <= 1'b1;
      end else begin
        r_arg_idx <= 1'b0;
      end
    end
  end

  // RAM write register: load on accepted pixel, clear once the RAM takes it
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_pix) begin
      r_ram_we    <= 1'b1;
      r_ram_addr  <= w_cur_addr;
      r_ram_wdata <= i_data;
    end else if (i_ram_ready) begin
      r_ram_we    <= 1'b0;
    end
  end

`ifdef SPI_FRAME_DONE_EN
  // Remember whether the pending write targets the window's last pixel
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ram_last <= 1'b0;
    end else if (w_pix) begin
      r_ram_last <= w_cur_last;
    end
  end

  assign w_frame_done = r_ram_we && i_ram_ready && r_ram_last;

  // Count completed windows, wrapping at 8 bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign o_frame_done = w_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
`endif

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: table-driven per-cycle vectors for spi_frame_ctrl plus
// hand-written reset/abort sequences and the optional SPI_FRAME_DONE_EN check.
module tb_spi_frame_ctrl;

  localparam int ADDR_W = 17;

  logic              CLK;
  logic              RST;
  logic              i_valid;
  logic              i_mode;
  logic [15:0]       i_data;
  logic              o_ready;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [15:0]       o_ram_wdata;
  logic              i_ram_ready;
  logic              o_busy;
  logic [1:0]        o_dbg_state;
`ifdef SPI_FRAME_DONE_EN
  logic              o_frame_done;
  logic [7:0]        o_frame_cnt;
`endif

  spi_frame_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_valid    (i_valid),
    .i_mode     (i_mode),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_wdata(o_ram_wdata),
    .i_ram_ready(i_ram_ready),
    .o_busy     (o_busy),
    .o_dbg_state(o_dbg_state)
`ifdef SPI_FRAME_DONE_EN
    ,
    .o_frame_done(o_frame_done),
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  // Clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic              v;
    logic              m;
    logic [15:0]       d;
    logic              r;
    logic              e_rdy;
    logic              e_busy;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [15:0]       e_wd;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic v, input logic m, input logic [15:0] d,
                              input logic r, input logic er, input logic eb,
                              input logic ew, input logic [ADDR_W-1:0] ea,
                              input logic [15:0] ed);
    vec_t t;
    t.v = v; t.m = m; t.d = d; t.r = r;
    t.e_rdy = er; t.e_busy = eb; t.e_we = ew; t.e_addr = ea; t.e_wd = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Driver: drive one cycle of inputs, compare at the falling edge
  task automatic apply(input vec_t t, input string tag);
    i_valid     = t.v;
    i_mode      = t.m;
    i_data      = t.d;
    i_ram_ready = t.r;
    @(negedge CLK);
    chk({tag, "_ready"}, 32'(o_ready), 32'(t.e_rdy));
    chk({tag, "_busy"},  32'(o_busy),  32'(t.e_busy));
    chk({tag, "_we"},    32'(o_ram_we), 32'(t.e_we));
    if (t.e_we) begin
      chk({tag, "_addr"},  32'(o_ram_addr),  32'(t.e_addr));
      chk({tag, "_wdata"}, 32'(o_ram_wdata), 32'(t.e_wd));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_rst();
    RST     = 1'b1;
    i_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ram_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    chk("rst_we",    32'(o_ram_we),    32'd0);
    chk("rst_addr",  32'(o_ram_addr),  32'd0);
    chk("rst_wdata", 32'(o_ram_wdata), 32'd0);
    chk("rst_busy",  32'(o_busy),      32'd0);
    @(posedge CLK);
    #1;

    // v  m  data      rdy | rdy busy we addr      wdata
    // RAMWR + 3 pixels at full-frame origin
    tbl.push_back(mk(1, 1, 16'h002C, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'h1111, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'h2222, 1, 1, 1, 1, 0,     16'h1111));
    tbl.push_back(mk(1, 0, 16'h3333, 1, 1, 1, 1, 1,     16'h2222));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 2,     16'h3333));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0,     16'h0));
    // CASET 10,11 ; PASET 5,6 ; RAMWR ; 5 pixels with wrap
    tbl.push_back(mk(1, 1, 16'h002A, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd10,   1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd11,   1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'h002B, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd5,    1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd6,    1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'h002C, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hA001, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hA002, 1, 1, 1, 1, 1610,  16'hA001));
    tbl.push_back(mk(1, 0, 16'hA003, 1, 1, 1, 1, 1611,  16'hA002));
    tbl.push_back(mk(1, 0, 16'hA004, 1, 1, 1, 1, 1930,  16'hA003));
    tbl.push_back(mk(1, 0, 16'hA005, 1, 1, 1, 1, 1931,  16'hA004));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 1610,  16'hA005));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0,     16'h0));
    // Stall for 4 cycles mid-burst
    tbl.push_back(mk(1, 0, 16'hB001, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hB002, 0, 0, 1, 1, 1611,  16'hB001));
    tbl.push_back(mk(1, 0, 16'hB002, 0, 0, 1, 1, 1611,  16'hB001));
    tbl.push_back(mk(1, 0, 16'hB002, 0, 0, 1, 1, 1611,  16'hB001));
    tbl.push_back(mk(1, 0, 16'hB002, 0, 0, 1, 1, 1611,  16'hB001));
    tbl.push_back(mk(1, 0, 16'hB002, 1, 1, 1, 1, 1611,  16'hB001));
    tbl.push_back(mk(1, 0, 16'hB003, 1, 1, 1, 1, 1930,  16'hB002));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 1931,  16'hB003));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0,     16'h0));
    // Command behind a stalled write, NOP abort, then discarded data
    tbl.push_back(mk(1, 0, 16'hC001, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 1, 1, 1610,  16'hC001));
    tbl.push_back(mk(1, 1, 16'h0000, 1, 1, 1, 1, 1610,  16'hC001));
    tbl.push_back(mk(1, 0, 16'hC002, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0,     16'h0));
    // CASET 400,500 -> x window 319..319 (y still 5..6)
    tbl.push_back(mk(1, 1, 16'h002A, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd400,  1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd500,  1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'h002C, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hD001, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hD002, 1, 1, 1, 1, 1919,  16'hD001));
    tbl.push_back(mk(1, 0, 16'hD003, 1, 1, 1, 1, 2239,  16'hD002));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 1919,  16'hD003));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0,     16'h0));
    // CASET 50,20 -> x 50..50 ; PASET 250,0 -> y 239..239 ; RAMWR with upper cmd bits set
    tbl.push_back(mk(1, 1, 16'h002A, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd50,   1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd20,   1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'h002B, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd250,  1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'd0,    1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 1, 16'hFF2C, 1, 1, 0, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hE001, 1, 1, 1, 0, 0,     16'h0));
    tbl.push_back(mk(1, 0, 16'hE002, 1, 1, 1, 1, 76530, 16'hE001));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 76530, 16'hE002));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0,     16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // RST while a write is stalled drops it
    apply(mk(1, 1, 16'h002C, 1, 1, 1, 0, 0,     16'h0),    "h_ramwr");
    apply(mk(1, 0, 16'hF001, 1, 1, 1, 0, 0,     16'h0),    "h_pix");
    apply(mk(0, 0, 16'h0000, 0, 0, 1, 1, 76530, 16'hF001), "h_stall");
    i_ram_ready = 1'b0;
    pulse_rst();
    @(negedge CLK);
    chk("h_rst_state", 32'(o_dbg_state), 32'd0);
    @(posedge CLK);
    #1;
    apply(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0), "h_rst_drop");

    // RST in S_ARG after one argument leaves the full-frame window
    apply(mk(1, 1, 16'h002A, 1, 1, 0, 0, 0, 16'h0), "h_caset");
    apply(mk(1, 0, 16'd100,  1, 1, 1, 0, 0, 16'h0), "h_arg0");
    pulse_rst();
    apply(mk(1, 1, 16'h002C, 1, 1, 0, 0, 0, 16'h0),    "h2_ramwr");
    apply(mk(1, 0, 16'hF101, 1, 1, 1, 0, 0, 16'h0),    "h2_p0");
    apply(mk(1, 0, 16'hF102, 1, 1, 1, 1, 0, 16'hF101), "h2_p1");
    apply(mk(0, 0, 16'h0000, 1, 1, 1, 1, 1, 16'hF102), "h2_d0");
    apply(mk(0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h0),    "h2_d1");

`ifdef SPI_FRAME_DONE_EN
    // 2x2 window, 8 pixels -> two frame completions
    begin
      int pulses;
      pulse_rst();
      apply(mk(1, 1, 16'h002A, 1, 1, 0, 0, 0, 16'h0), "fd_caset");
      apply(mk(1, 0, 16'd0,    1, 1, 1, 0, 0, 16'h0), "fd_xs");
      apply(mk(1, 0, 16'd1,    1, 1, 1, 0, 0, 16'h0), "fd_xe");
      apply(mk(1, 1, 16'h002B, 1, 1, 0, 0, 0, 16'h0), "fd_paset");
      apply(mk(1, 0, 16'd0,    1, 1, 1, 0, 0, 16'h0), "fd_ys");
      apply(mk(1, 0, 16'd1,    1, 1, 1, 0, 0, 16'h0), "fd_ye");
      apply(mk(1, 1, 16'h002C, 1, 1, 0, 0, 0, 16'h0), "fd_ramwr");
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
        i_valid = (i < 8); i_mode = 1'b0; i_data = 16'(16'h5000 + i); i_ram_ready = 1'b1;
        @(negedge CLK);
        if (o_frame_done) pulses++;
        @(posedge CLK);
        #1;
      end
      chk("fd_pulses", 32'(pulses), 32'd2);
      chk("fd_cnt", 32'(o_frame_cnt), 32'd2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
